// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit with a shift-register scoreboard
// of in-flight register writers and a saturating stall-cycle counter.
module fwd_hazard_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned LATW  = 3,
    parameter int unsigned SELW  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_adv,
    input  logic            flush,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic            issue_use_rs1,
    input  logic            issue_use_rs2,
    input  logic            issue_wb,
    input  logic [4:0]      issue_rd,
    input  logic [LATW-1:0] issue_lat,
    output logic [SELW-1:0] fwd_sel1,
    output logic [SELW-1:0] fwd_sel2,
    output logic            stall,
    output logic [31:0]     stall_cnt
);

    localparam int unsigned REGW = 5;

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] wb_q;
    logic [REGW-1:0]  rd_q  [DEPTH];
    logic [LATW-1:0]  lat_q [DEPTH];

    logic             haz1;
    logic             haz2;

    // Youngest matching writer wins; returns {hazard, select}.
    function automatic logic [SELW:0] lookup(input logic use_rs, input logic [REGW-1:0] rs);
        logic            found;
        logic            haz;
        logic [SELW-1:0] sel;
        found = 1'b0;
        haz   = 1'b0;
        sel   = '0;
        if (use_rs && (rs != REGW'(0))) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (!found && v_q[k] && wb_q[k] && (rd_q[k] == rs)) begin
                    found = 1'b1;
                    if (k >= int'(lat_q[k])) begin
                        sel = SELW'(k + 1);
                    end else begin
                        haz = 1'b1;
                    end
                end
            end
        end
        return {haz, sel};
    endfunction

    always_comb begin
        {haz1, fwd_sel1} = lookup(issue_use_rs1, issue_rs1);
        {haz2, fwd_sel2} = lookup(issue_use_rs2, issue_rs2);
        stall = issue_valid & ~flush & (haz1 | haz2);
    end

    // Scoreboard shift/hold/flush and stall accounting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q       <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                rd_q[k]  <= '0;
                lat_q[k] <= '0;
            end
        end else if (pipe_adv) begin
            for (int k = 1; k < int'(DEPTH); k++) begin
                v_q[k]   <= (k == 1 && flush) ? 1'b0 : v_q[k-1];
                wb_q[k]  <= wb_q[k-1];
                rd_q[k]  <= rd_q[k-1];
                lat_q[k] <= lat_q[k-1];
            end
            v_q[0]   <= issue_valid & ~stall & ~flush;
            wb_q[0]  <= issue_wb & (issue_rd != REGW'(0));
            rd_q[0]  <= issue_rd;
            lat_q[0] <= issue_lat;
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end else if (flush) begin
            v_q[0] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit (DEPTH=2): forwarding, load-use,
// freeze/flush, x0 handling, long latency, reset and counter saturation.
module tb_fwd_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic        pipe_adv;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_use_rs1;
    logic        issue_use_rs2;
    logic        issue_wb;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_lat;
    logic [2:0]  fwd_sel1;
    logic [2:0]  fwd_sel2;
    logic        stall;
    logic [31:0] stall_cnt;

    int vectors = 0;
    int errs    = 0;

    fwd_hazard_unit #(.DEPTH(2), .LATW(3), .SELW(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pipe_adv      (pipe_adv),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_wb      (issue_wb),
        .issue_rd      (issue_rd),
        .issue_lat     (issue_lat),
        .fwd_sel1      (fwd_sel1),
        .fwd_sel2      (fwd_sel2),
        .stall         (stall),
        .stall_cnt     (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic wb, input logic [4:0] rd, input logic [2:0] lat);
        issue_valid   = v;
        issue_rs1     = rs1;
        issue_use_rs1 = u1;
        issue_rs2     = rs2;
        issue_use_rs2 = u2;
        issue_wb      = wb;
        issue_rd      = rd;
        issue_lat     = lat;
        #1;
    endtask

    task automatic expect3(input string tag, input logic [2:0] s1, input logic [2:0] s2,
                           input logic st);
        chk({tag, ".sel1"}, 32'(fwd_sel1), 32'(s1));
        chk({tag, ".sel2"}, 32'(fwd_sel2), 32'(s2));
        chk({tag, ".stall"}, 32'(stall), 32'(st));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        pipe_adv = 1'b1;
        flush    = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset state; add x5,x1,x2 (lat 0)
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 3'd0);
        expect3("reset", 3'd0, 3'd0, 1'b0);
        chk("reset.cnt", stall_cnt, 32'd0);
        tick();

        // add x6,x5,x5 -> both from entry 0
        drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 3'd0);
        expect3("alu_b2b", 3'd1, 3'd1, 1'b0);
        tick();

        // lw x7,0(x6) lat 1 ; x6 in entry 0
        drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 3'd1);
        expect3("lw_issue", 3'd1, 3'd0, 1'b0);
        tick();

        // add x8,x7,x1 -> load-use stall
        drive(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 1'b1, 5'd8, 3'd0);
        expect3("ld_use1", 3'd0, 3'd0, 1'b1);
        chk("ld_use1.cnt", stall_cnt, 32'd0);
        tick();
        expect3("ld_use2", 3'd2, 3'd0, 1'b0);
        chk("ld_use2.cnt", stall_cnt, 32'd1);
        tick();

        // sub x9,x8,x7 -> x8 entry 0, x7 retired
        drive(1'b1, 5'd8, 1'b1, 5'd7, 1'b1, 1'b1, 5'd9, 3'd0);
        expect3("retired", 3'd1, 3'd0, 1'b0);
        tick();

        // addi x3,x0 ; addi x3,x3 ; sub x9,x3,x3 -> youngest
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 3'd0);
        expect3("x3a", 3'd0, 3'd0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 3'd0);
        expect3("x3b", 3'd1, 3'd0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 5'd9, 3'd0);
        expect3("youngest", 3'd1, 3'd1, 1'b0);
        tick();

        // lui x0 ; add x1,x0,x0
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 3'd0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd1, 3'd0);
        expect3("x0_src", 3'd0, 3'd0, 1'b0);
        tick();

        // store with rs2 unused; rd field 1 but no write
        drive(1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 1'b0, 5'd1, 3'd0);
        expect3("store", 3'd1, 3'd0, 1'b0);
        tick();
        // non-writer in entry 0 with rd=1 must be skipped
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0);
        expect3("nowb_skip", 3'd2, 3'd0, 1'b0);
        tick();

        // lw x4 lat 1, then freeze with dependent at issue
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 3'd1);
        tick();
        pipe_adv = 1'b0;
        drive(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 1'b1, 5'd10, 3'd0);
        for (int i = 0; i < 3; i++) begin
            expect3("freeze", 3'd0, 3'd0, 1'b1);
            chk("freeze.cnt", stall_cnt, 32'd1);
            tick();
        end
        expect3("freeze_end", 3'd0, 3'd0, 1'b1);
        chk("freeze_end.cnt", stall_cnt, 32'd1);
        pipe_adv = 1'b1;
        flush    = 1'b1;
        #1;
        chk("flush.stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        expect3("post_flush", 3'd0, 3'd0, 1'b0);
        chk("post_flush.cnt", stall_cnt, 32'd1);
        tick();

        // lw x11 ; flush with freeze clears only entry 0
        drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 3'd1);
        expect3("x10_fwd", 3'd1, 3'd0, 1'b0);
        tick();
        pipe_adv = 1'b0;
        flush    = 1'b1;
        drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b1, 5'd12, 3'd0);
        expect3("frz_flush", 3'd2, 3'd0, 1'b0);
        tick();
        pipe_adv = 1'b1;
        flush    = 1'b0;
        drive(1'b1, 5'd11, 1'b1, 5'd10, 1'b1, 1'b1, 5'd12, 3'd0);
        expect3("frz_flush_after", 3'd0, 3'd2, 1'b0);
        tick();

        // long-latency writer x13 lat 2 >= DEPTH
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd13, 3'd2);
        tick();
        drive(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 1'b1, 5'd14, 3'd0);
        expect3("longlat0", 3'd0, 3'd0, 1'b1);
        tick();
        expect3("longlat1", 3'd0, 3'd0, 1'b1);
        chk("longlat1.cnt", stall_cnt, 32'd2);
        tick();
        expect3("longlat2", 3'd0, 3'd0, 1'b0);
        chk("longlat2.cnt", stall_cnt, 32'd3);
        tick();

        // reset mid-stream with x14 in entry 0
        drive(1'b1, 5'd14, 1'b1, 5'd14, 1'b1, 1'b1, 5'd15, 3'd0);
        expect3("pre_rst", 3'd1, 3'd1, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        expect3("mid_rst", 3'd0, 3'd0, 1'b0);
        chk("mid_rst.cnt", stall_cnt, 32'd0);
        tick();

        // saturation: lw x16 lat 1, preload counter, force a stall
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd16, 3'd1);
        tick();
        drive(1'b1, 5'd16, 1'b1, 5'd0, 1'b0, 1'b1, 5'd17, 3'd0);
        chk("sat.stall", 32'(stall), 32'd1);
        dut.stall_cnt = 32'hFFFF_FFFF;
        tick();
        chk("sat.cnt", stall_cnt, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised operand-forwarding and load-use hazard unit for the RISC-V core pipeline, and the successor to the fixed three-stage forwarding-select logic.
- Tracks up to DEPTH in-flight register writers in a shift-register scoreboard.
- For the instruction at decode/issue, produces per-operand forward selects (which stage to bypass from, 0 = regfile) and a stall request when a needed result is not yet produced.
- Keeps a saturating stall-cycle counter, read by the CSR block.

Parameters:
- DEPTH, 2: number of tracked in-flight stages after issue (entry 0 = youngest); legal range 1..7.
- LATW, 3: width of the per-instruction result-latency field.
- SELW, 3: forward-select width; must satisfy 2^SELW > DEPTH.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: synchronous reset, active low.
- pipe_adv, input, 1: pipeline advance enable. 0 freezes the scoreboard (e.g. memory wait).
- flush, input, 1: kill the issuing instruction and entry 0 (branch/jump redirect).
- issue_valid, input, 1: an instruction is presented at issue.
- issue_rs1, input, 5: source register 1.
- issue_rs2, input, 5: source register 2.
- issue_use_rs1, input, 1: instruction reads rs1.
- issue_use_rs2, input, 1: instruction reads rs2 (R-type, store, branch).
- issue_wb, input, 1: instruction writes rd.
- issue_rd, input, 5: destination register.
- issue_lat, input, LATW: first entry index at which the result is forwardable (ALU/LUI/AUIPC 0, JAL/JALR 0, load 1, CSR 1).
- fwd_sel1, output, SELW: rs1 source. 0 = regfile; k = entry k-1.
- fwd_sel2, output, SELW: rs2 source, same encoding.
- stall, output, 1: hold issue and insert a bubble.
- stall_cnt, output, 32: saturating count of stall cycles.

Behaviour:
- Scoreboard state: entry[k] = {v, wb, rd[4:0], lat[LATW-1:0]} for k = 0..DEPTH-1.
- Reset (rst_n=0 at a clk edge): all entry v=0 and stall_cnt=0. Since outputs are combinational from state and inputs, fwd_sel1/2=0 and stall=0 in the cycle after reset.
- Reset has priority over pipe_adv and flush. Reset mid-operation discards all entries.
- Operand lookup, done independently for rs1 and rs2:
  - Skip the lookup if use=0 or rs=x0; select 0, no hazard.
  - Otherwise scan k = 0 upward and take the first entry with v & wb & rd==rs. Youngest match wins; older matches are ignored even if ready.
  - Match with k >= entry.lat: select k+1, no hazard.
  - Match with k < entry.lat: hazard.
  - No match: select 0.
- stall = issue_valid & ~flush & (hazard1 | hazard2). While stall=1, fwd_sel values are don't-care for the datapath but still driven per the lookup.
- Shift, on a clk edge with rst_n=1 and pipe_adv=1:
  - entry[k] <= entry[k-1] for k >= 1.
  - entry[0] <= {1, issue_wb & (issue_rd != 0), issue_rd, issue_lat} if issue_valid & ~stall & ~flush.
  - Otherwise entry[0] <= bubble (v=0).
  - The oldest entry (DEPTH-1) falls off; its value is then in the regfile.
- Flush:
  - flush=1 with pipe_adv=1: entry[0] is not shifted into entry[1] (entry[1] <= bubble), and entry[0] <= bubble.
  - flush=1 with pipe_adv=0: entry[0].v <= 0, other entries hold.
- pipe_adv=0 (no flush): all entries hold; lookup and stall still evaluated every cycle.
- stall_cnt increments by 1 on each edge where stall=1 and pipe_adv=1, and saturates at 0xFFFFFFFF.
- rd=x0 writers are recorded with wb=0 and never forward.
- lat >= DEPTH: the result is never forwardable, so dependents stall until the entry retires and then read the regfile (select 0).

Test Plan:
- ALU back-to-back: issue add x5 (lat 0), next cycle add x6,x5,x5 → fwd_sel1=1, fwd_sel2=1, stall=0.
- Load-use, DEPTH=2: issue lw x7 (lat 1), next cycle add x8,x7,x1 → stall=1, stall_cnt=1. Following cycle → fwd_sel1=2, stall=0, and the add enters entry 0.
- Youngest wins: addi x3 then addi x3 then sub x9,x3,x3 → fwd_sel1=fwd_sel2=1, not 2.
- x0 and unused operand: lui x0 then add x1,x0,x0 → selects 0. A store with use_rs2=0 matching rd → fwd_sel2=0.
- Freeze and flush: lw x4; hold pipe_adv=0 for 3 cycles with a dependent at issue → stall=1, stall_cnt unchanged, entries hold. Then flush=1 with pipe_adv=1 → entries 0 and 1 cleared, dependent → select 0, stall=0.
- Reset mid-stream: entries valid, rst_n=0 for one edge → next cycle fwd_sel1=fwd_sel2=0, stall=0, stall_cnt=0. Saturation check: preload stall_cnt=0xFFFFFFFF, force a stall → value stays 0xFFFFFFFF.
